// File: rtl/hack_mem_pkg.sv
// Shared constants and types for the Hack data-memory stage: address map,
// region decode enum and video read FSM states.
package hack_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned VID_AW = 13;

  localparam logic [ADDR_W-1:0] RAM_BASE    = 15'h0000;
  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] SCREEN_END  = 15'h6000;
  localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    RegionRam,
    RegionScreen,
    RegionKbd,
    RegionUnmapped
  } region_e;

  typedef enum logic [1:0] {
    VidIdle,
    VidWait,
    VidResp
  } vid_state_e;

endpackage

// File: rtl/hack_memory_map_if.sv
// CPU data bus, keyboard event inputs and video read port of the Hack memory stage.
interface hack_memory_map_if;
  import hack_mem_pkg::*;

  logic [ADDR_W-1:0] addressM;
  logic [DATA_W-1:0] outM;
  logic              writeM;
  logic [DATA_W-1:0] inM;

  logic              kbd_valid;
  logic              kbd_release;
  logic [DATA_W-1:0] kbd_code;

  logic              vid_req;
  logic [VID_AW-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  modport master (
    output addressM, outM, writeM, kbd_valid, kbd_release, kbd_code, vid_req, vid_addr,
    input  inM, vid_data, vid_valid
  );

  modport slave (
    input  addressM, outM, writeM, kbd_valid, kbd_release, kbd_code, vid_req, vid_addr,
    output inM, vid_data, vid_valid
  );

endinterface

// File: rtl/sync_ram.sv
// Single-port read-first RAM with registered output; contents are not reset.
module sync_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hack_memory_map.sv
// Hack data-memory stage: RAM/screen/keyboard decode, keyboard latch and a video
// read port that borrows the screen buffer whenever the CPU is not using it.
module hack_memory_map import hack_mem_pkg::*; #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned RAM_WORDS    = 16384,
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter int unsigned KBD_ADDR     = 24576
) (
  input logic             clk,
  input logic             reset,
  hack_memory_map_if.slave bus
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned ScrAw = $clog2(SCREEN_WORDS);

  region_e    region, region_q;
  vid_state_e state_q, state_d;

  logic                  cpu_scr;
  logic                  vid_issue;
  logic                  scr_en;
  logic                  scr_we;
  logic [ScrAw-1:0]      scr_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] scr_rdata;
  logic [DATA_WIDTH-1:0] kbd_q;
  logic [DATA_WIDTH-1:0] kbd_rd_q;
  logic [DATA_WIDTH-1:0] vid_hold_q;

  // Exact range compares so out-of-range addresses never alias into a memory.
  always_comb begin
    if (bus.addressM < SCREEN_BASE) begin
      region = RegionRam;
    end else if (bus.addressM < SCREEN_END) begin
      region = RegionScreen;
    end else if (bus.addressM == ADDR_WIDTH'(KBD_ADDR)) begin
      region = RegionKbd;
    end else begin
      region = RegionUnmapped;
    end
  end

  assign cpu_scr  = (region == RegionScreen);
  assign scr_en   = cpu_scr || vid_issue;
  assign scr_we   = cpu_scr && bus.writeM;
  assign scr_addr = cpu_scr ? ScrAw'(bus.addressM - SCREEN_BASE) : bus.vid_addr;

  sync_ram #(
    .DEPTH (RAM_WORDS),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (region == RegionRam),
    .we    ((region == RegionRam) && bus.writeM),
    .addr  (bus.addressM[RamAw-1:0]),
    .wdata (bus.outM),
    .rdata (ram_rdata)
  );

  sync_ram #(
    .DEPTH (SCREEN_WORDS),
    .WIDTH (DATA_WIDTH)
  ) u_screen (
    .clk   (clk),
    .en    (scr_en),
    .we    (scr_we),
    .addr  (scr_addr),
    .wdata (bus.outM),
    .rdata (scr_rdata)
  );

  // The CPU always wins the screen port; video waits for an off-screen cycle.
  always_comb begin
    state_d   = state_q;
    vid_issue = 1'b0;
    unique case (state_q)
      VidIdle: begin
        if (bus.vid_req) begin
          if (!cpu_scr) begin
            vid_issue = 1'b1;
            state_d   = VidResp;
          end else begin
            state_d   = VidWait;
          end
        end
      end
      VidWait: begin
        if (!bus.vid_req) begin
          state_d = VidIdle;
        end else if (!cpu_scr) begin
          vid_issue = 1'b1;
          state_d   = VidResp;
        end
      end
      VidResp: state_d = VidIdle;
      default: state_d = VidIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      region_q   <= RegionUnmapped;
      kbd_q      <= '0;
      kbd_rd_q   <= '0;
      state_q    <= VidIdle;
      vid_hold_q <= '0;
    end else begin
      region_q <= region;
      // Sampled alongside the memory reads so keyboard reads see pre-edge data.
      kbd_rd_q <= kbd_q;
      if (bus.kbd_valid) begin
        kbd_q <= bus.kbd_code;
      end else if (bus.kbd_release) begin
        kbd_q <= '0;
      end
      state_q <= state_d;
      if (state_q == VidResp) begin
        vid_hold_q <= scr_rdata;
      end
    end
  end

  always_comb begin
    unique case (region_q)
      RegionRam:    bus.inM = ram_rdata;
      RegionScreen: bus.inM = scr_rdata;
      RegionKbd:    bus.inM = kbd_rd_q;
      default:      bus.inM = '0;
    endcase
  end

  assign bus.vid_valid = (state_q == VidResp);
  assign bus.vid_data  = bus.vid_valid ? scr_rdata : vid_hold_q;

endmodule

// File: tb/tb_hack_memory_map.sv
// Self-checking bench for hack_memory_map against an address-map reference model.
module tb_hack_memory_map;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hack_memory_map_if bus ();

  hack_memory_map dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ram_m [16384];
  logic [15:0] scr_m [8192];
  logic [15:0] kbd_m = 16'h0;

  function automatic logic [15:0] model_read(input logic [14:0] a);
    logic [12:0] si;
    si = 13'(a - 15'h4000);
    if (a < 15'h4000) return ram_m[a[13:0]];
    if (a < 15'h6000) return scr_m[si];
    if (a == 15'h6000) return kbd_m;
    return 16'h0;
  endfunction

  // One CPU cycle; exp is what inM must show after the edge.
  task automatic step(input logic [14:0] a, input logic [15:0] d, input logic we,
                      input logic kv, input logic kr, input logic [15:0] kc,
                      output logic [15:0] exp);
    logic [12:0] si;
    bus.addressM    = a;
    bus.outM        = d;
    bus.writeM      = we;
    bus.kbd_valid   = kv;
    bus.kbd_release = kr;
    bus.kbd_code    = kc;
    exp = model_read(a);
    @(posedge clk);
    #1;
    si = 13'(a - 15'h4000);
    if (we) begin
      if (a < 15'h4000) ram_m[a[13:0]] = d;
      else if (a < 15'h6000) scr_m[si] = d;
    end
    if (kv) kbd_m = kc;
    else if (kr) kbd_m = 16'h0;
    bus.writeM      = 1'b0;
    bus.kbd_valid   = 1'b0;
    bus.kbd_release = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a, output logic [15:0] exp);
    step(a, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, exp);
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    logic [15:0] e;
    step(a, d, 1'b1, 1'b0, 1'b0, 16'h0, e);
  endtask

  task automatic test_reset();
    logic [15:0] e;
    bus.addressM = 15'h0; bus.outM = 16'h0; bus.writeM = 1'b0;
    bus.kbd_valid = 1'b0; bus.kbd_release = 1'b0; bus.kbd_code = 16'h0;
    bus.vid_req = 1'b0; bus.vid_addr = 13'h0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.inM !== 16'h0) begin n_fail++; $display("FAIL reset_inM: got %h want 0000", bus.inM); end
    n_tests++;
    if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vid_valid: got %b want 0", bus.vid_valid); end
    n_tests++;
    if (bus.vid_data !== 16'h0) begin n_fail++; $display("FAIL reset_vid_data: got %h want 0000", bus.vid_data); end
    reset = 1'b1;
    rd(15'h6000, e);
    n_tests++;
    if (bus.inM !== 16'h0) begin n_fail++; $display("FAIL reset_kbd: got %h want 0000", bus.inM); end
  endtask

  task automatic test_ram();
    logic [15:0] e;
    wr(15'd5, 16'h1234);
    rd(15'd5, e);
    n_tests++;
    if (bus.inM !== 16'h1234) begin n_fail++; $display("FAIL ram_rd5: got %h want 1234", bus.inM); end
    rd(15'd6, e);
    n_tests++;
    if (bus.inM === 16'h1234) begin n_fail++; $display("FAIL ram_rd6: got %h want not 1234", bus.inM); end
    wr(15'h3FFF, 16'h3F3F);
    rd(15'h3FFF, e);
    n_tests++;
    if (bus.inM !== 16'h3F3F) begin n_fail++; $display("FAIL ram_top: got %h want 3f3f", bus.inM); end
  endtask

  task automatic test_read_first();
    logic [15:0] e;
    wr(15'h4010, 16'h1111);
    step(15'h4010, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0, e);
    n_tests++;
    if (bus.inM !== 16'h1111) begin n_fail++; $display("FAIL read_first_old: got %h want 1111", bus.inM); end
    rd(15'h4010, e);
    n_tests++;
    if (bus.inM !== 16'hBEEF) begin n_fail++; $display("FAIL read_first_new: got %h want beef", bus.inM); end
    wr(15'h5FFF, 16'h5F5F);
    rd(15'h5FFF, e);
    n_tests++;
    if (bus.inM !== 16'h5F5F) begin n_fail++; $display("FAIL screen_top: got %h want 5f5f", bus.inM); end
  endtask

  task automatic test_kbd();
    logic [15:0] e;
    step(15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'd140, e);
    rd(15'h6000, e);
    n_tests++;
    if (bus.inM !== 16'd140) begin n_fail++; $display("FAIL kbd_load: got %0d want 140", bus.inM); end
    // Read in the load cycle still returns the previous code.
    step(15'h6000, 16'h0, 1'b0, 1'b1, 1'b1, 16'd131, e);
    n_tests++;
    if (bus.inM !== 16'd140) begin n_fail++; $display("FAIL kbd_latency: got %0d want 140", bus.inM); end
    rd(15'h6000, e);
    n_tests++;
    if (bus.inM !== 16'd131) begin n_fail++; $display("FAIL kbd_both: got %0d want 131", bus.inM); end
    step(15'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'd99, e);
    rd(15'h6000, e);
    n_tests++;
    if (bus.inM !== 16'd0) begin n_fail++; $display("FAIL kbd_release: got %0d want 0", bus.inM); end
    step(15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'd55, e);
    wr(15'h6000, 16'd7);
    rd(15'h6000, e);
    n_tests++;
    if (bus.inM !== 16'd55) begin n_fail++; $display("FAIL kbd_write_ignored: got %0d want 55", bus.inM); end
  endtask

  task automatic test_unmapped();
    logic [15:0] e;
    wr(15'h2001, 16'h0101);
    wr(15'h4001, 16'h0202);
    wr(15'h6001, 16'hFFFF);
    wr(15'h7FFF, 16'hFFFF);
    rd(15'h6001, e);
    n_tests++;
    if (bus.inM !== 16'h0) begin n_fail++; $display("FAIL unmapped_6001: got %h want 0000", bus.inM); end
    rd(15'h7FFF, e);
    n_tests++;
    if (bus.inM !== 16'h0) begin n_fail++; $display("FAIL unmapped_7fff: got %h want 0000", bus.inM); end
    rd(15'h2001, e);
    n_tests++;
    if (bus.inM !== 16'h0101) begin n_fail++; $display("FAIL alias_ram: got %h want 0101", bus.inM); end
    rd(15'h4001, e);
    n_tests++;
    if (bus.inM !== 16'h0202) begin n_fail++; $display("FAIL alias_scr: got %h want 0202", bus.inM); end
    rd(15'h5FFF, e);
    n_tests++;
    if (bus.inM !== 16'h5F5F) begin n_fail++; $display("FAIL alias_scr_top: got %h want 5f5f", bus.inM); end
    rd(15'h3FFF, e);
    n_tests++;
    if (bus.inM !== 16'h3F3F) begin n_fail++; $display("FAIL alias_ram_top: got %h want 3f3f", bus.inM); end
  endtask

  task automatic test_arbitration();
    logic [15:0] e;
    logic [15:0] got;
    int          cnt;
    int          first;
    wr(15'h4003, 16'hA5A5);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'd3;
    for (int i = 0; i < 4; i++) begin
      rd(15'h4000, e);
      n_tests++;
      if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL arb_blocked%0d: vid_valid=%b want 0", i, bus.vid_valid); end
    end
    cnt = 0; first = -1; got = 16'h0;
    for (int i = 1; i <= 6; i++) begin
      rd(15'd5, e);
      if (bus.vid_valid === 1'b1) begin
        cnt++;
        if (first < 0) begin first = i; got = bus.vid_data; end
        bus.vid_req = 1'b0;
      end
    end
    n_tests++;
    if (cnt != 1) begin n_fail++; $display("FAIL arb_pulse_count: got %0d want 1", cnt); end
    n_tests++;
    if (first != 1) begin n_fail++; $display("FAIL arb_pulse_cycle: got %0d want 1", first); end
    n_tests++;
    if (got !== 16'hA5A5) begin n_fail++; $display("FAIL arb_data: got %h want a5a5", got); end

    // A CPU write one cycle before the video read is visible to video.
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'd7;
    wr(15'h4007, 16'h5A5A);
    n_tests++;
    if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL wr_then_vid_early: vid_valid=%b want 0", bus.vid_valid); end
    rd(15'd5, e);
    n_tests++;
    if (bus.vid_valid !== 1'b1 || bus.vid_data !== scr_m[7]) begin
      n_fail++;
      $display("FAIL wr_then_vid: valid=%b data=%h want 1 %h", bus.vid_valid, bus.vid_data, scr_m[7]);
    end
    bus.vid_req = 1'b0;
    rd(15'd5, e);
    n_tests++;
    if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL vid_single_pulse: vid_valid=%b want 0", bus.vid_valid); end

    // Request withdrawn while waiting produces no response.
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'd3;
    rd(15'h4000, e);
    bus.vid_req = 1'b0;
    rd(15'h4000, e);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      rd(15'd5, e);
      if (bus.vid_valid !== 1'b0) cnt++;
    end
    n_tests++;
    if (cnt != 0) begin n_fail++; $display("FAIL wait_drop: got %0d pulses want 0", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int          k;
    for (int i = 0; i < 8; i++) wr(15'(15'h4010 + i), 16'($urandom));
    k = 0;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'h10;
    for (int i = 0; i < 20 && k < 8; i++) begin
      rd(15'd5, e);
      n_tests++;
      if (bus.vid_valid !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL b2b_valid%0d: got %b want %b", i, bus.vid_valid, (i % 2) == 0);
      end
      if (bus.vid_valid === 1'b1) begin
        n_tests++;
        if (bus.vid_data !== scr_m[16 + k]) begin
          n_fail++;
          $display("FAIL b2b_data%0d: got %h want %h", k, bus.vid_data, scr_m[16 + k]);
        end
        k++;
        bus.vid_addr = 13'(16 + k);
        if (k == 8) bus.vid_req = 1'b0;
      end
    end
    bus.vid_req = 1'b0;
    n_tests++;
    if (k != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", k); end
    rd(15'd5, e);
  endtask

  task automatic test_random();
    logic [14:0] pool [12];
    logic [15:0] e;
    logic [14:0] a;
    pool = '{15'h0000, 15'h0001, 15'h0002, 15'h1000, 15'h3FFE, 15'h3FFF,
             15'h4000, 15'h4001, 15'h5FFF, 15'h6000, 15'h6001, 15'h7FFF};
    for (int i = 0; i < 12; i++) wr(pool[i], 16'($urandom));
    for (int i = 0; i < 200; i++) begin
      a = pool[$urandom_range(0, 11)];
      step(a, 16'($urandom), 1'($urandom), ($urandom % 4) == 0, ($urandom % 4) == 0,
           16'($urandom), e);
      n_tests++;
      if (bus.inM !== e) begin n_fail++; $display("FAIL rand%0d addr %h: got %h want %h", i, a, bus.inM, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    int          cnt;
    wr(15'd100, 16'hCAFE);
    step(15'h0, 16'h0, 1'b0, 1'b1, 1'b0, 16'd77, e);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 13'd3;
    rd(15'h4003, e);
    n_tests++;
    if (bus.inM !== 16'hA5A5) begin n_fail++; $display("FAIL pre_reset_inM: got %h want a5a5", bus.inM); end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.inM !== 16'h0) begin n_fail++; $display("FAIL mid_reset_inM: got %h want 0000", bus.inM); end
    n_tests++;
    if (bus.vid_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", bus.vid_valid); end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.vid_req = 1'b0;
    kbd_m       = 16'h0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      rd(15'd5, e);
      if (bus.vid_valid !== 1'b0) cnt++;
    end
    n_tests++;
    if (cnt != 0) begin n_fail++; $display("FAIL reset_drop_vid: got %0d pulses want 0", cnt); end
    rd(15'd100, e);
    n_tests++;
    if (bus.inM !== 16'hCAFE) begin n_fail++; $display("FAIL ram_survives_reset: got %h want cafe", bus.inM); end
    rd(15'h6000, e);
    n_tests++;
    if (bus.inM !== 16'h0) begin n_fail++; $display("FAIL kbd_cleared: got %h want 0000", bus.inM); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram();
    test_read_first();
    test_kbd();
    test_unmapped();
    test_arbitration();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
